axis_fft_frame_sink: RTL and testbench

- AXI-Stream slave that terminates the complex FFT/IFFT output stream.
- Captures one N_POINT frame into an internal buffer and tracks the peak-magnitude bin while it fills.
- Holds the frame, with backpressure, until the consumer reads it via a random-access port and acknowledges it.
- Pairs with the existing stream master (signal_generator / fft_mdc m_axis) as the receiving end on silicon and in benches.

---
 rtl/axis_fft_frame_sink_if.sv | 27 ++
 rtl/axis_fft_frame_sink.sv | 202 ++++++++++++++++++++
 tb/tb_axis_fft_frame_sink.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fft_frame_sink_if.sv
// AXI-Stream bundle carrying complex FFT samples into axis_fft_frame_sink.
//   tvalid : sample valid (master -> slave)
//   tdata  : {real, imag}, each NB_DATA bits signed, real in MSBs
//   tlast  : last sample of a frame
//   tready : sink ready (slave -> master)
interface axis_fft_frame_sink_if #(
  parameter int unsigned NB_DATA = 12
);
  logic                   tvalid;
  logic [2*NB_DATA-1:0]   tdata;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_fft_frame_sink.sv
// AXI-Stream sink for complex FFT/IFFT output. Captures one N_POINT frame into a buffer,
// tracks the peak |re|+|im| bin while filling, then holds the frame (tready low) until the
// consumer has read it through the random-access port and acknowledged it.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   s_axis_data      AXI-Stream slave (tvalid/tdata/tlast in, tready out)
//   i_rd_addr        buffer read address; o_rd_data returns mem[i_rd_addr] one cycle later
//   o_frame_valid    complete frame held; i_frame_ack releases it
//   o_peak_idx/mag   bin and magnitude of the peak in the held frame
//   o_frame_cnt      frames accepted (wraps)
//   o_err_tlast      sticky tlast misalignment flag, cleared by i_clr_err (set wins)
//
// Build option: define AXIS_FFT_FRAME_SINK_BITREV_EN to write samples at the bit-reversed
// arrival count, putting an MDC bit-reversed stream into natural frequency order.
module axis_fft_frame_sink #(
  parameter int unsigned NB_DATA = 12,
  parameter int unsigned N_POINT = 8,
  parameter int unsigned NB_ADDR = 3,
  parameter int unsigned NB_FCNT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  axis_fft_frame_sink_if.slave   s_axis_data,
  input  logic [NB_ADDR-1:0]     i_rd_addr,
  output logic [2*NB_DATA-1:0]   o_rd_data,
  output logic                   o_frame_valid,
  input  logic                   i_frame_ack,
  output logic [NB_ADDR-1:0]     o_peak_idx,
  output logic [NB_DATA:0]       o_peak_mag,
  output logic [NB_FCNT-1:0]     o_frame_cnt,
  output logic                   o_err_tlast,
  input  logic                   i_clr_err
);

  typedef enum logic [0:0] {SFill, SHold} state_e;

  localparam logic [NB_ADDR-1:0] LastCnt = NB_ADDR'(N_POINT - 1);

  state_e               state_q, state_d;
  logic [NB_ADDR-1:0]   wr_cnt_q, wr_cnt_d;
  logic [NB_ADDR-1:0]   run_idx_q, run_idx_d;
  logic [NB_DATA:0]     run_mag_q, run_mag_d;
  logic [NB_ADDR-1:0]   peak_idx_q, peak_idx_d;
  logic [NB_DATA:0]     peak_mag_q, peak_mag_d;
  logic [NB_FCNT-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 err_q, err_d;
  logic                 tready_q, tready_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [2*NB_DATA-1:0] rd_data_q;

  logic [2*NB_DATA-1:0] mem [N_POINT];

  logic [NB_DATA-1:0]   re, im;
  logic [NB_DATA-1:0]   abs_re, abs_im;
  logic [NB_DATA:0]     mag;
  logic [NB_ADDR-1:0]   wr_addr;
  logic                 xfer, last_beat, early_last, frame_done;
  logic                 take;
  logic [NB_ADDR-1:0]   cand_idx;
  logic [NB_DATA:0]     cand_mag;

  // Two's complement magnitude; the most negative value maps to 2^(NB_DATA-1) as unsigned.
  function automatic logic [NB_DATA-1:0] abs_val(input logic [NB_DATA-1:0] v);
    return v[NB_DATA-1] ? (~v + 1'b1) : v;
  endfunction

  assign re = s_axis_data.tdata[2*NB_DATA-1:NB_DATA];
  assign im = s_axis_data.tdata[NB_DATA-1:0];

  always_comb begin
    abs_re = abs_val(re);
    abs_im = abs_val(im);
    mag    = {1'b0, abs_re} + {1'b0, abs_im};
  end

`ifdef AXIS_FFT_FRAME_SINK_BITREV_EN
  always_comb begin
    wr_addr = '0;
    for (int i = 0; i < int'(NB_ADDR); i++) begin
      wr_addr[i] = wr_cnt_q[int'(NB_ADDR) - 1 - i];
    end
  end
`else
  assign wr_addr = wr_cnt_q;
`endif

  // tready is registered, so a transfer can only happen while filling.
  assign xfer       = s_axis_data.tvalid & tready_q;
  assign last_beat  = (wr_cnt_q == LastCnt);
  assign early_last = xfer & s_axis_data.tlast & ~last_beat;
  assign frame_done = xfer & last_beat;

  // First sample loads unconditionally; later ones need a strictly greater magnitude so
  // ties keep the earliest bin.
  always_comb begin
    take     = (wr_cnt_q == '0) || (mag > run_mag_q);
    cand_idx = take ? wr_addr : run_idx_q;
    cand_mag = take ? mag : run_mag_q;
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    run_idx_d   = run_idx_q;
    run_mag_d   = run_mag_q;
    peak_idx_d  = peak_idx_q;
    peak_mag_d  = peak_mag_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    unique case (state_q)
      SFill: begin
        if (xfer) begin
          if (early_last) begin
            // Partial frame is dropped; the next sample starts a fresh frame and peak.
            wr_cnt_d = '0;
          end else if (last_beat) begin
            state_d     = SHold;
            wr_cnt_d    = '0;
            run_idx_d   = cand_idx;
            run_mag_d   = cand_mag;
            peak_idx_d  = cand_idx;
            peak_mag_d  = cand_mag;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end else begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
            run_idx_d = cand_idx;
            run_mag_d = cand_mag;
          end
        end
      end
      SHold: begin
        if (i_frame_ack) begin
          state_d = SFill;
        end
      end
      default: state_d = SFill;
    endcase

    if (i_clr_err) begin
      err_d = 1'b0;
    end
    if (early_last || (frame_done && !s_axis_data.tlast)) begin
      err_d = 1'b1;
    end

    tready_d      = (state_d == SFill);
    frame_valid_d = (state_d == SHold);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= SFill;
      wr_cnt_q      <= '0;
      run_idx_q     <= '0;
      run_mag_q     <= '0;
      peak_idx_q    <= '0;
      peak_mag_q    <= '0;
      frame_cnt_q   <= '0;
      err_q         <= 1'b0;
      tready_q      <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      run_idx_q     <= run_idx_d;
      run_mag_q     <= run_mag_d;
      peak_idx_q    <= peak_idx_d;
      peak_mag_q    <= peak_mag_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
      tready_q      <= tready_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Frame buffer has no reset; contents are only meaningful while a frame is held.
  always_ff @(posedge i_clk) begin
    if (xfer) begin
      mem[wr_addr] <= s_axis_data.tdata;
    end
  end

  // Nonblocking read returns the pre-write word on a same-address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[i_rd_addr];
    end
  end

  assign s_axis_data.tready = tready_q;
  assign o_rd_data          = rd_data_q;
  assign o_frame_valid      = frame_valid_q;
  assign o_peak_idx         = peak_idx_q;
  assign o_peak_mag         = peak_mag_q;
  assign o_frame_cnt        = frame_cnt_q;
  assign o_err_tlast        = err_q;

endmodule

// File: tb/tb_axis_fft_frame_sink.sv
// Scoreboard bench for axis_fft_frame_sink: stimulus pushes expected frame results and read
// words into queues; a monitor pops and compares on o_frame_valid rising and on read returns.
module tb_axis_fft_frame_sink;
  localparam int NB_DATA = 12;

  logic        i_clk;
  logic        i_rst_n;
  logic [2:0]  i_rd_addr;
  logic [23:0] o_rd_data;
  logic        o_frame_valid;
  logic        i_frame_ack;
  logic [2:0]  o_peak_idx;
  logic [12:0] o_peak_mag;
  logic [7:0]  o_frame_cnt;
  logic        o_err_tlast;
  logic        i_clr_err;

  axis_fft_frame_sink_if #(.NB_DATA(NB_DATA)) s_axis_data ();

  axis_fft_frame_sink dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .s_axis_data   (s_axis_data),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_frame_valid (o_frame_valid),
    .i_frame_ack   (i_frame_ack),
    .o_peak_idx    (o_peak_idx),
    .o_peak_mag    (o_peak_mag),
    .o_frame_cnt   (o_frame_cnt),
    .o_err_tlast   (o_err_tlast),
    .i_clr_err     (i_clr_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  cnt;
    logic [2:0]  idx;
    logic [12:0] mag;
    logic        err;
  } frame_t;

  frame_t      frame_q[$];
  logic [23:0] rd_q[$];
  logic [23:0] mdl_mem [8];
  int          total = 0;
  int          bad = 0;
  int          exp_cnt = 0;
  bit          rd_req = 0;
  bit          rd_chk = 0;
  bit          fv_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] waddr(input int k);
    logic [2:0] kk;
    kk = k[2:0];
`ifdef AXIS_FFT_FRAME_SINK_BITREV_EN
    return {kk[0], kk[1], kk[2]};
`else
    return kk;
`endif
  endfunction

  // Monitor
  always @(posedge i_clk) rd_chk <= rd_req;

  always @(negedge i_clk) begin
    frame_t e;
    if (o_frame_valid && !fv_prev) begin
      if (frame_q.size() == 0) begin
        check("spurious_frame_valid", 32'd1, 32'd0);
      end else begin
        e = frame_q.pop_front();
        check("frame_cnt", 32'(o_frame_cnt), 32'(e.cnt));
        check("peak_idx", 32'(o_peak_idx), 32'(e.idx));
        check("peak_mag", 32'(o_peak_mag), 32'(e.mag));
        check("err_at_frame", 32'(o_err_tlast), 32'(e.err));
      end
    end
    fv_prev = o_frame_valid;
    if (rd_chk) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_data", 32'(o_rd_data), 32'(rd_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, 32'(s_axis_data.tready), 32'd0);
    check({tag, "_fv"}, 32'(o_frame_valid), 32'd0);
    check({tag, "_idx"}, 32'(o_peak_idx), 32'd0);
    check({tag, "_mag"}, 32'(o_peak_mag), 32'd0);
    check({tag, "_cnt"}, 32'(o_frame_cnt), 32'd0);
    check({tag, "_err"}, 32'(o_err_tlast), 32'd0);
    check({tag, "_rd"}, 32'(o_rd_data), 32'd0);
  endtask

  task automatic send(input int re, input int im, input bit last, input int k);
    int n = 0;
    while (!s_axis_data.tready && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!s_axis_data.tready) check("tready_timeout", 32'd0, 32'd1);
    s_axis_data.tdata  = {re[11:0], im[11:0]};
    s_axis_data.tlast  = last;
    s_axis_data.tvalid = 1'b1;
    mdl_mem[waddr(k)]  = {re[11:0], im[11:0]};
    @(posedge i_clk);
    #1;
    s_axis_data.tvalid = 1'b0;
    s_axis_data.tlast  = 1'b0;
  endtask

  // pk is the arrival position of the peak; it is mapped to the buffer address here.
  task automatic send_frame(input int ra[8], input int ia[8], input bit last7, input bit clr7,
                            input int pk, input int pmag, input bit perr);
    frame_t e;
    exp_cnt++;
    e.cnt = 8'(exp_cnt);
    e.idx = waddr(pk);
    e.mag = 13'(pmag);
    e.err = perr;
    frame_q.push_back(e);
    for (int k = 0; k < 8; k++) begin
      if (k == 7 && clr7) i_clr_err = 1'b1;
      send(ra[k], ia[k], (k == 7) && last7, k);
      i_clr_err = 1'b0;
    end
  endtask

  task automatic rd(input int a);
    i_rd_addr = a[2:0];
    rd_q.push_back(mdl_mem[a[2:0]]);
    rd_req = 1'b1;
    @(posedge i_clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic ack_frame(input string tag);
    i_frame_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_frame_ack = 1'b0;
    @(negedge i_clk);
    check({tag, "_ack_fv"}, 32'(o_frame_valid), 32'd0);
    check({tag, "_ack_tready"}, 32'(s_axis_data.tready), 32'd1);
  endtask

  task automatic clr_pulse(input string tag);
    i_clr_err = 1'b1;
    @(posedge i_clk);
    #1;
    i_clr_err = 1'b0;
    check({tag, "_err_cleared"}, 32'(o_err_tlast), 32'd0);
  endtask

  initial begin
    int ra[8];
    int ia[8];
    int n;
    i_rst_n            = 1'b0;
    s_axis_data.tvalid = 1'b0;
    s_axis_data.tdata  = '0;
    s_axis_data.tlast  = 1'b0;
    i_rd_addr          = '0;
    i_frame_ack        = 1'b0;
    i_clr_err          = 1'b0;
    #1;
    check_reset_outputs("rst0");
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("rst1");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("post_rst_tready", 32'(s_axis_data.tready), 32'd1);

    // Ramp frame: re=k, im=-k, peak at bin 7 with magnitude 14.
    for (int k = 0; k < 8; k++) begin ra[k] = k; ia[k] = -k; end
    send_frame(ra, ia, 1'b1, 1'b0, 7, 14, 1'b0);
    @(negedge i_clk);
    check("a_fv", 32'(o_frame_valid), 32'd1);
    check("a_tready", 32'(s_axis_data.tready), 32'd0);
    rd(3);
`ifndef AXIS_FFT_FRAME_SINK_BITREV_EN
    check("a_rd3_hand", 32'(o_rd_data), 32'h003FFD);
`endif
    rd(7);
    rd(0);
    // Valid during hold must not transfer.
    s_axis_data.tvalid = 1'b1;
    s_axis_data.tdata  = 24'hABCABC;
    s_axis_data.tlast  = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    s_axis_data.tvalid = 1'b0;
    s_axis_data.tlast  = 1'b0;
    check("hold_fv", 32'(o_frame_valid), 32'd1);
    check("hold_cnt", 32'(o_frame_cnt), 32'd1);
    check("hold_idx", 32'(o_peak_idx), 32'(waddr(7)));
    check("hold_mag", 32'(o_peak_mag), 32'd14);
    rd(3);
    ack_frame("a");

    // Early tlast on the 5th sample: error, partial frame dropped.
    for (int k = 0; k < 5; k++) send(100, 100, k == 4, k);
    @(negedge i_clk);
    check("early_err", 32'(o_err_tlast), 32'd1);
    check("early_cnt", 32'(o_frame_cnt), 32'd1);
    check("early_fv", 32'(o_frame_valid), 32'd0);
    // Ack while filling is ignored.
    i_frame_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_frame_ack = 1'b0;
    check("fill_ack_tready", 32'(s_axis_data.tready), 32'd1);

    // Clean frame, tie at bins 3 and 4 (mag 8) keeps bin 3.
    ra = '{5, -3, 0, 7, -8, 2, 1, -1};
    ia = '{0, 4, -6, -1, 0, 2, 0, 0};
    send_frame(ra, ia, 1'b1, 1'b0, 3, 8, 1'b1);
    rd(1);
    rd(4);
    ack_frame("b");
    clr_pulse("b");

    // Missing tlast, with clear coinciding with the error: set wins.
    for (int k = 0; k < 8; k++) begin ra[k] = (k == 6) ? 100 : k; ia[k] = 0; end
    send_frame(ra, ia, 1'b0, 1'b1, 6, 100, 1'b1);
    @(negedge i_clk);
    check("c_fv", 32'(o_frame_valid), 32'd1);
    check("c_err_set_wins", 32'(o_err_tlast), 32'd1);
    rd(6);
    ack_frame("c");
    clr_pulse("c");

    // Extremes: -2048 at bin 2 and bin 5 tie at 2048, earliest kept.
    for (int k = 0; k < 8; k++) begin ra[k] = 0; ia[k] = 0; end
    ra[2] = -2048;
    ia[5] = -2048;
    send_frame(ra, ia, 1'b1, 1'b0, 2, 2048, 1'b0);
    rd(int'(waddr(2)));
    check("d_peak_word", 32'(o_rd_data), 32'h800000);
    ack_frame("d");

    // Reset mid-frame after 4 samples.
    for (int k = 0; k < 4; k++) send(50, 0, 1'b0, k);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_cnt = 0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("midrst_tready", 32'(s_axis_data.tready), 32'd1);
    check("midrst_no_fv", 32'(o_frame_valid), 32'd0);

    for (int k = 0; k < 8; k++) begin ra[k] = 10 + k; ia[k] = k - 3; end
    send_frame(ra, ia, 1'b1, 1'b0, 7, 21, 1'b0);
    for (int a = 0; a < 8; a++) rd(a);
    ack_frame("e");

    n = 0;
    while ((frame_q.size() != 0 || rd_q.size() != 0) && n < 20) begin
      @(posedge i_clk);
      n++;
    end
    @(negedge i_clk);
    check("frame_q_drained", 32'(frame_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
